// File: rtl/formula_nested_isqrt_pipe_pkg.sv
// Shared constants and helpers for the nested isqrt formula pipe.
// Latency/depth helpers plus a behavioural reference of the formula.
package formula_pipe_pkg;

    localparam int MAX_N = 8;
    localparam int MAX_W = 64;

    // End-to-end latency: N isqrt pipes, N-1 sum registers, one output reg.
    function automatic int calc_lat(input int n, input int l);
        return n * l + n;
    endfunction

    function automatic int cnt_w(input int n, input int l);
        return $clog2(calc_lat(n, l) + 1);
    endfunction

    // Cycles between arg acceptance and x[j]'s entry into isqrt_j.
    function automatic int stage_delay(input int n, input int l, input int j);
        return (n - 1 - j) * (l + 1);
    endfunction

    function automatic longint unsigned isqrt_ref(
        input longint unsigned x,
        input int              w
    );
        longint unsigned r;
        longint unsigned t;
        r = 0;
        for (int b = w / 2 - 1; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= x) r = t;
        end
        return r;
    endfunction

    function automatic longint unsigned formula_nested_fn(
        input logic [MAX_N*MAX_W-1:0] args,
        input int                     n,
        input int                     w
    );
        longint unsigned              mask;
        longint unsigned              xk;
        longint unsigned              r;
        logic [MAX_N*MAX_W-1:0]       sh;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        r    = 0;
        for (int k = n - 1; k >= 0; k--) begin
            sh = args >> (k * w);
            xk = sh[63:0] & mask;
            if (k == n - 1) r = isqrt_ref(xk, w);
            else            r = isqrt_ref((xk + r) & mask, w);
        end
        return r;
    endfunction

endpackage

// File: rtl/formula_nested_isqrt_pipe_if.sv
// Argument/result bundle of the nested isqrt pipe.
// master: drives arg_vld/args; slave: drives res_vld/res/inflight.
interface formula_nested_isqrt_pipe_if #(
    parameter int N_ARGS        = 3,
    parameter int WIDTH         = 32,
    parameter int ISQRT_LATENCY = 16
);
    import formula_pipe_pkg::*;

    localparam int CW = cnt_w(N_ARGS, ISQRT_LATENCY);

    logic                      arg_vld;
    logic [N_ARGS*WIDTH-1:0]   args;
    logic                      res_vld;
    logic [WIDTH/2-1:0]        res;
    logic [CW-1:0]             inflight;

    modport master (
        output arg_vld, args,
        input  res_vld, res, inflight
    );

    modport slave (
        input  arg_vld, args,
        output res_vld, res, inflight
    );

endinterface

// File: rtl/formula_nested_isqrt_pipe_isqrt_add_stage.sv
// One outer stage: delay x[j], add the inner root, register, take isqrt.
// Ports: clk, rst, x_vld_i/x_i (raw arg), prev_vld_i/prev_i (inner root), y_vld_o/y_o.
module isqrt_add_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x_vld_i,
    input  logic [WIDTH-1:0]   x_i,
    input  logic               prev_vld_i,
    input  logic [WIDTH/2-1:0] prev_i,
    output logic               y_vld_o,
    output logic [WIDTH/2-1:0] y_o
);
    logic               dly_vld;
    logic [WIDTH-1:0]   dly_x;
    logic               sum_en;
    logic [WIDTH-1:0]   sum_d;
    logic [WIDTH-1:0]   sum_q;
    logic               sum_vld_q;

    // The sum register is the last cycle of x[j]'s delay, so the
    // line itself is one shorter than the stage delay.
    shift_register_with_valid #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dly (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (x_vld_i),
        .in_i      (x_i),
        .out_vld_o (dly_vld),
        .out_o     (dly_x)
    );

    assign sum_en = prev_vld_i & dly_vld;
    // Wraps modulo 2^WIDTH.
    assign sum_d  = dly_x + {{(WIDTH/2){1'b0}}, prev_i};

    always_ff @(posedge clk) begin
        if (rst) sum_vld_q <= 1'b0;
        else     sum_vld_q <= sum_en;
    end

    always_ff @(posedge clk) begin
        if (sum_en) sum_q <= sum_d;
    end

    isqrt_pipe #(
        .WIDTH (WIDTH)
    ) u_isqrt (
        .clk     (clk),
        .rst     (rst),
        .x_vld_i (sum_vld_q),
        .x_i     (sum_q),
        .y_vld_o (y_vld_o),
        .y_o     (y_o)
    );

endmodule

// File: rtl/isqrt_pipe.sv
// Pipelined integer square root, one result bit per stage (WIDTH/2 cycles).
// Ports: clk, rst, x_vld_i/x_i in, y_vld_o/y_o out; data regs valid-gated.
module isqrt_pipe #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x_vld_i,
    input  logic [WIDTH-1:0]   x_i,
    output logic               y_vld_o,
    output logic [WIDTH/2-1:0] y_o
);
    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0] xs [H];
    logic [H-1:0]     rm [H];
    logic [H-1:0]     rt [H];
    logic             vl [H];

    assign xs[0] = x_i;
    assign rm[0] = '0;
    assign rt[0] = '0;
    assign vl[0] = x_vld_i;

    for (genvar s = 0; s < H; s++) begin : g_st
        logic [H+1:0] rem_w;
        logic [H+1:0] trial_w;
        logic         ge_w;

        // Bring down the next two radicand bits; x is pre-shifted so
        // they always sit at the top.
        assign rem_w   = {rm[s], xs[s][WIDTH-1 -: 2]};
        assign trial_w = {rt[s], 2'b01};
        assign ge_w    = (rem_w >= trial_w);

        if (s < H - 1) begin : g_mid
            logic [WIDTH-1:0] x_q;
            logic [H-1:0]     r_q;
            logic [H-1:0]     t_q;
            logic             v_q;

            always_ff @(posedge clk) begin
                if (rst) v_q <= 1'b0;
                else     v_q <= vl[s];
            end

            // Remainder of an intermediate stage stays below 2^H.
            always_ff @(posedge clk) begin
                if (vl[s]) begin
                    x_q <= xs[s] << 2;
                    r_q <= ge_w ? H'(rem_w - trial_w) : H'(rem_w);
                    t_q <= {rt[s][H-2:0], ge_w};
                end
            end

            assign xs[s+1] = x_q;
            assign rm[s+1] = r_q;
            assign rt[s+1] = t_q;
            assign vl[s+1] = v_q;
        end else begin : g_last
            logic [H-1:0] t_q;
            logic         v_q;

            always_ff @(posedge clk) begin
                if (rst) v_q <= 1'b0;
                else     v_q <= vl[s];
            end

            always_ff @(posedge clk) begin
                if (vl[s]) t_q <= {rt[s][H-2:0], ge_w};
            end

            assign y_o     = t_q;
            assign y_vld_o = v_q;
        end
    end

endmodule

// File: rtl/shift_register_with_valid.sv
// Delay line of DEPTH (>= 1) stages; each data stage loads only with its valid.
// Ports: clk, rst, in_vld_i/in_i in, out_vld_o/out_o out.
module shift_register_with_valid #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld_i,
    input  logic [WIDTH-1:0] in_i,
    output logic             out_vld_o,
    output logic [WIDTH-1:0] out_o
);
    logic [DEPTH-1:0] v_q;
    logic [WIDTH-1:0] d_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q[0] <= in_vld_i;
            for (int i = 1; i < DEPTH; i++) v_q[i] <= v_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (in_vld_i) d_q[0] <= in_i;
        for (int i = 1; i < DEPTH; i++) begin
            if (v_q[i-1]) d_q[i] <= d_q[i-1];
        end
    end

    assign out_vld_o = v_q[DEPTH-1];
    assign out_o     = d_q[DEPTH-1];

endmodule

// File: rtl/formula_nested_isqrt_pipe.sv
// res = isqrt(x0 + isqrt(x1 + ... isqrt(x[N-1]))), fixed latency LAT.
// Ports: clk, rst, bus (slave: arg_vld/args in, res_vld/res/inflight out).
module formula_nested_isqrt_pipe
    import formula_pipe_pkg::*;
#(
    parameter int N_ARGS        = 3,
    parameter int WIDTH         = 32,
    // Must equal WIDTH/2, the latency of isqrt_pipe.
    parameter int ISQRT_LATENCY = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    formula_nested_isqrt_pipe_if.slave  bus
);
    localparam int CW = cnt_w(N_ARGS, ISQRT_LATENCY);
    localparam int HW = WIDTH / 2;

    logic          yv [N_ARGS];
    logic [HW-1:0] y  [N_ARGS];

    logic          res_vld_q;
    logic [HW-1:0] res_q;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] inflight_d;

    isqrt_pipe #(
        .WIDTH (WIDTH)
    ) u_inner (
        .clk     (clk),
        .rst     (rst),
        .x_vld_i (bus.arg_vld),
        .x_i     (bus.args[(N_ARGS-1)*WIDTH +: WIDTH]),
        .y_vld_o (yv[N_ARGS-1]),
        .y_o     (y[N_ARGS-1])
    );

    for (genvar j = 0; j < N_ARGS - 1; j++) begin : g_stage
        isqrt_add_stage #(
            .WIDTH (WIDTH),
            .DEPTH (stage_delay(N_ARGS, ISQRT_LATENCY, j) - 1)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .x_vld_i    (bus.arg_vld),
            .x_i        (bus.args[j*WIDTH +: WIDTH]),
            .prev_vld_i (yv[j+1]),
            .prev_i     (y[j+1]),
            .y_vld_o    (yv[j]),
            .y_o        (y[j])
        );
    end

    always_comb begin
        inflight_d = inflight_q;
        if (bus.arg_vld && !res_vld_q)      inflight_d = inflight_q + 1'b1;
        else if (!bus.arg_vld && res_vld_q) inflight_d = inflight_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_vld_q  <= 1'b0;
            res_q      <= '0;
            inflight_q <= '0;
        end else begin
            res_vld_q  <= yv[0];
            if (yv[0]) res_q <= y[0];
            inflight_q <= inflight_d;
        end
    end

    assign bus.res_vld  = res_vld_q;
    assign bus.res      = res_q;
    assign bus.inflight = inflight_q;

endmodule

// File: tb/tb_formula_nested_isqrt_pipe.sv
// Scoreboard bench for formula_nested_isqrt_pipe: N=3/W=32, N=1/W=32, N=4/W=16.
// Expected results are queued at drive time and popped on each res_vld.
module tb_formula_nested_isqrt_pipe;
    import formula_pipe_pkg::*;

    localparam int LAT3 = 51;
    localparam int LAT1 = 17;
    localparam int LAT4 = 36;

    typedef struct {
        logic [31:0] val;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t q3[$];
    exp_t q1[$];
    exp_t q4[$];

    formula_nested_isqrt_pipe_if #(.N_ARGS(3), .WIDTH(32), .ISQRT_LATENCY(16)) if3();
    formula_nested_isqrt_pipe_if #(.N_ARGS(1), .WIDTH(32), .ISQRT_LATENCY(16)) if1();
    formula_nested_isqrt_pipe_if #(.N_ARGS(4), .WIDTH(16), .ISQRT_LATENCY(8))  if4();

    formula_nested_isqrt_pipe #(.N_ARGS(3), .WIDTH(32), .ISQRT_LATENCY(16)) u3 (
        .clk (clk), .rst (rst), .bus (if3)
    );
    formula_nested_isqrt_pipe #(.N_ARGS(1), .WIDTH(32), .ISQRT_LATENCY(16)) u1 (
        .clk (clk), .rst (rst), .bus (if1)
    );
    formula_nested_isqrt_pipe #(.N_ARGS(4), .WIDTH(16), .ISQRT_LATENCY(8)) u4 (
        .clk (clk), .rst (rst), .bus (if4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref3(input logic [95:0] a);
        logic [MAX_N*MAX_W-1:0] t;
        longint unsigned        r;
        t       = '0;
        t[95:0] = a;
        r       = formula_nested_fn(t, 3, 32);
        return r[15:0];
    endfunction

    function automatic logic [15:0] ref1(input logic [31:0] a);
        logic [MAX_N*MAX_W-1:0] t;
        longint unsigned        r;
        t       = '0;
        t[31:0] = a;
        r       = formula_nested_fn(t, 1, 32);
        return r[15:0];
    endfunction

    function automatic logic [7:0] ref4(input logic [63:0] a);
        logic [MAX_N*MAX_W-1:0] t;
        longint unsigned        r;
        t       = '0;
        t[63:0] = a;
        r       = formula_nested_fn(t, 4, 16);
        return r[7:0];
    endfunction

    function automatic logic [31:0] rnd32();
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 1000));
        return $urandom;
    endfunction

    // Scoreboard monitors: value, exact due cycle, missed pulses, inflight bound.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            n_cmp++;
            if (int'(if3.inflight) > LAT3) begin
                n_bad++;
                $display("FAIL n3_inflight_bound: got %0d limit %0d", if3.inflight, LAT3);
            end
            if (if3.res_vld) begin
                n_cmp++;
                if (q3.size() == 0) begin
                    n_bad++;
                    $display("FAIL n3_unexpected: res=%0d at cyc %0d, none expected", if3.res, cyc);
                end else begin
                    e = q3.pop_front();
                    if (if3.res !== e.val[15:0] || cyc !== e.due) begin
                        n_bad++;
                        $display("FAIL n3_result: got %0d @%0d expected %0d @%0d",
                                 if3.res, cyc, e.val[15:0], e.due);
                    end
                end
            end else if (q3.size() != 0 && q3[0].due < cyc) begin
                n_cmp++;
                n_bad++;
                e = q3.pop_front();
                $display("FAIL n3_missed: no pulse, expected %0d @%0d", e.val[15:0], e.due);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            n_cmp++;
            if (int'(if1.inflight) > LAT1) begin
                n_bad++;
                $display("FAIL n1_inflight_bound: got %0d limit %0d", if1.inflight, LAT1);
            end
            if (if1.res_vld) begin
                n_cmp++;
                if (q1.size() == 0) begin
                    n_bad++;
                    $display("FAIL n1_unexpected: res=%0d at cyc %0d, none expected", if1.res, cyc);
                end else begin
                    e = q1.pop_front();
                    if (if1.res !== e.val[15:0] || cyc !== e.due) begin
                        n_bad++;
                        $display("FAIL n1_result: got %0d @%0d expected %0d @%0d",
                                 if1.res, cyc, e.val[15:0], e.due);
                    end
                end
            end else if (q1.size() != 0 && q1[0].due < cyc) begin
                n_cmp++;
                n_bad++;
                e = q1.pop_front();
                $display("FAIL n1_missed: no pulse, expected %0d @%0d", e.val[15:0], e.due);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            n_cmp++;
            if (int'(if4.inflight) > LAT4) begin
                n_bad++;
                $display("FAIL n4_inflight_bound: got %0d limit %0d", if4.inflight, LAT4);
            end
            if (if4.res_vld) begin
                n_cmp++;
                if (q4.size() == 0) begin
                    n_bad++;
                    $display("FAIL n4_unexpected: res=%0d at cyc %0d, none expected", if4.res, cyc);
                end else begin
                    e = q4.pop_front();
                    if (if4.res !== e.val[7:0] || cyc !== e.due) begin
                        n_bad++;
                        $display("FAIL n4_result: got %0d @%0d expected %0d @%0d",
                                 if4.res, cyc, e.val[7:0], e.due);
                    end
                end
            end else if (q4.size() != 0 && q4[0].due < cyc) begin
                n_cmp++;
                n_bad++;
                e = q4.pop_front();
                $display("FAIL n4_missed: no pulse, expected %0d @%0d", e.val[7:0], e.due);
            end
        end
    end

    task automatic drive3(input logic [95:0] a, input logic v, input logic [15:0] e);
        @(negedge clk);
        if3.arg_vld = v;
        if3.args    = a;
        if (v) q3.push_back('{val: {16'd0, e}, due: cyc + LAT3});
    endtask

    task automatic drive1(input logic [31:0] a, input logic v, input logic [15:0] e);
        @(negedge clk);
        if1.arg_vld = v;
        if1.args    = a;
        if (v) q1.push_back('{val: {16'd0, e}, due: cyc + LAT1});
    endtask

    task automatic drive4(input logic [63:0] a, input logic v, input logic [7:0] e);
        @(negedge clk);
        if4.arg_vld = v;
        if4.args    = a;
        if (v) q4.push_back('{val: {24'd0, e}, due: cyc + LAT4});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q3.size() + q1.size() + q4.size()) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if ((q3.size() + q1.size() + q4.size()) != 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d results outstanding, expected 0",
                     name, q3.size() + q1.size() + q4.size());
            q3.delete();
            q1.delete();
            q4.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if3.arg_vld = 1'b0; if3.args = '0;
        if1.arg_vld = 1'b0; if1.args = '0;
        if4.arg_vld = 1'b0; if4.args = '0;
        repeat (3) @(negedge clk);
        n_cmp += 9;
        if (if3.res_vld !== 1'b0) begin n_bad++; $display("FAIL rst_n3_vld: got %b need 0", if3.res_vld); end
        if (if3.res !== 16'd0)    begin n_bad++; $display("FAIL rst_n3_res: got %0d need 0", if3.res); end
        if (if3.inflight !== '0)  begin n_bad++; $display("FAIL rst_n3_inflight: got %0d need 0", if3.inflight); end
        if (if1.res_vld !== 1'b0) begin n_bad++; $display("FAIL rst_n1_vld: got %b need 0", if1.res_vld); end
        if (if1.res !== 16'd0)    begin n_bad++; $display("FAIL rst_n1_res: got %0d need 0", if1.res); end
        if (if1.inflight !== '0)  begin n_bad++; $display("FAIL rst_n1_inflight: got %0d need 0", if1.inflight); end
        if (if4.res_vld !== 1'b0) begin n_bad++; $display("FAIL rst_n4_vld: got %b need 0", if4.res_vld); end
        if (if4.res !== 8'd0)     begin n_bad++; $display("FAIL rst_n4_res: got %0d need 0", if4.res); end
        if (if4.inflight !== '0)  begin n_bad++; $display("FAIL rst_n4_inflight: got %0d need 0", if4.inflight); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        drive3({32'd16, 32'd5, 32'd6}, 1'b1, 16'd3);
        drive3('0, 1'b0, '0);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (if3.inflight !== 6'd1) begin
            n_bad++;
            $display("FAIL single_inflight_mid: got %0d need 1", if3.inflight);
        end
        wait_drain("single");
        @(negedge clk);
        n_cmp += 2;
        if (if3.inflight !== 6'd0) begin
            n_bad++;
            $display("FAIL single_inflight_end: got %0d need 0", if3.inflight);
        end
        if (if3.res !== 16'd3) begin
            n_bad++;
            $display("FAIL single_hold: got %0d need 3", if3.res);
        end
    endtask

    task automatic test_wrap();
        drive3({32'd1, 32'd0, 32'hFFFF_FFFF}, 1'b1, 16'd0);
        drive3('0, 1'b0, '0);
        wait_drain("wrap");
    endtask

    task automatic test_back_to_back();
        drive3({32'd16,  32'd5, 32'd6},  1'b1, 16'd3);
        drive3({32'd100, 32'd6, 32'd12}, 1'b1, 16'd4);
        drive3({32'd0,   32'd0, 32'd0},  1'b1, 16'd0);
        drive3('0, 1'b0, '0);
        wait_drain("b2b");
        repeat (5) @(negedge clk);
        n_cmp += 2;
        if (if3.res !== 16'd0) begin
            n_bad++;
            $display("FAIL b2b_hold: got %0d need 0", if3.res);
        end
        if (if3.res_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle_vld: got %b need 0", if3.res_vld);
        end
    endtask

    task automatic test_random();
        int            sent;
        logic          v;
        logic [95:0]   a;
        sent = 0;
        while (sent < 1000) begin
            v = ($urandom_range(0, 3) != 0);
            a = {rnd32(), rnd32(), rnd32()};
            if (v) sent++;
            drive3(a, v, v ? ref3(a) : 16'd0);
        end
        drive3('0, 1'b0, '0);
        wait_drain("random");
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 5; i++) begin
            drive3({32'd100, 32'd6, 32'd12}, 1'b1, 16'd4);
        end
        drive3('0, 1'b0, '0);
        drive3('0, 1'b0, '0);
        @(negedge clk);
        rst = 1'b1;
        q3.delete();
        @(negedge clk);
        n_cmp += 3;
        if (if3.inflight !== 6'd0) begin
            n_bad++;
            $display("FAIL midrst_inflight: got %0d need 0", if3.inflight);
        end
        if (if3.res !== 16'd0) begin
            n_bad++;
            $display("FAIL midrst_res: got %0d need 0", if3.res);
        end
        if (if3.res_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_vld: got %b need 0", if3.res_vld);
        end
        rst         = 1'b0;
        if3.arg_vld = 1'b1;
        if3.args    = {32'd16, 32'd5, 32'd6};
        q3.push_back('{val: 32'd3, due: cyc + LAT3});
        drive3('0, 1'b0, '0);
        repeat (LAT3 + 10) @(negedge clk);
        wait_drain("midrst");
    endtask

    task automatic test_variants();
        logic [31:0] a1;
        logic [63:0] a4;
        drive1(32'd81, 1'b1, 16'd9);
        drive1('0, 1'b0, '0);
        for (int i = 0; i < 20; i++) begin
            a1 = rnd32();
            drive1(a1, 1'b1, ref1(a1));
        end
        drive1('0, 1'b0, '0);
        drive4({16'd16, 16'd5, 16'd6, 16'd13}, 1'b1, 8'd4);
        drive4('0, 1'b0, '0);
        for (int i = 0; i < 20; i++) begin
            a4 = {$urandom, $urandom};
            drive4(a4, ($urandom_range(0, 2) != 0), ref4(a4));
        end
        drive4('0, 1'b0, '0);
        wait_drain("variants");
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        test_variants();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
